// File: rtl/lc3b_mem_arbiter.sv
// Shares one memory port between LC-3b I-fetch and D load/store; the winner's request is registered one cycle after grant.
// Losers simply keep requesting; the strobe holds until mem_resp, and the response is routed back combinationally.
module lc3b_mem_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        i_read,
  input  logic [15:0] i_address,
  output logic [15:0] i_rdata,
  output logic        i_resp,

  input  logic        d_read,
  input  logic        d_write,
  input  logic [15:0] d_address,
  input  logic [15:0] d_wdata,
  input  logic [1:0]  d_wmask,
  output logic [15:0] d_rdata,
  output logic        d_resp,

  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_wmask,
  input  logic [15:0] mem_rdata,
  input  logic        mem_resp
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [15:0] address;
    logic [15:0] wdata;
    logic [1:0]  wmask;
  } mem_req_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t   state, state_nxt;
  logic     last_grant, last_grant_nxt;
  mem_req_t req_q, req_nxt;
  logic     req_i, req_d, pick_d;

  assign req_i = i_read;
  assign req_d = d_read | d_write;

  // D wins when alone, under fixed priority, or when I held the last grant.
  assign pick_d = req_d & (~req_i | FIXED_PRIO | (last_grant == GRANT_I));

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    req_nxt        = req_q;
    case (state)
      IDLE: begin
        if (pick_d) begin
          state_nxt       = BUSY_D;
          last_grant_nxt  = GRANT_D;
          req_nxt.address = d_address;
          req_nxt.wdata   = d_wdata;
          if (d_write) begin
            req_nxt.read  = 1'b0;
            req_nxt.write = 1'b1;
            req_nxt.wmask = d_wmask;
          end else begin
            req_nxt.read  = 1'b1;
            req_nxt.write = 1'b0;
            req_nxt.wmask = 2'b00;
          end
        end else if (req_i) begin
          state_nxt       = BUSY_I;
          last_grant_nxt  = GRANT_I;
          req_nxt.address = i_address;
          req_nxt.wdata   = 16'h0000;
          req_nxt.read    = 1'b1;
          req_nxt.write   = 1'b0;
          req_nxt.wmask   = 2'b00;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_resp) begin
          state_nxt     = IDLE;
          req_nxt.read  = 1'b0;
          req_nxt.write = 1'b0;
        end
      end
      default: begin
        state_nxt     = IDLE;
        req_nxt.read  = 1'b0;
        req_nxt.write = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_D;
      req_q      <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      req_q      <= req_nxt;
    end
  end

  assign mem_read    = req_q.read;
  assign mem_write   = req_q.write;
  assign mem_address = req_q.address;
  assign mem_wdata   = req_q.wdata;
  assign mem_wmask   = req_q.wmask;

  // Responses are qualified by state so a stray mem_resp in IDLE goes nowhere.
  assign i_resp  = (state == BUSY_I) & mem_resp;
  assign d_resp  = (state == BUSY_D) & mem_resp;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Directed bench for lc3b_mem_arbiter: round-robin instance plus a fixed-priority instance.
module tb_lc3b_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        i_read, i_resp, d_read, d_write, d_resp;
  logic [15:0] i_address, i_rdata, d_address, d_wdata, d_rdata;
  logic [1:0]  d_wmask, mem_wmask;
  logic        mem_read, mem_write, mem_resp;
  logic [15:0] mem_address, mem_wdata, mem_rdata;

  logic        f_i_read, f_i_resp, f_d_read, f_d_write, f_d_resp;
  logic [15:0] f_i_address, f_i_rdata, f_d_address, f_d_wdata, f_d_rdata;
  logic [1:0]  f_d_wmask, f_mem_wmask;
  logic        f_mem_read, f_mem_write, f_mem_resp;
  logic [15:0] f_mem_address, f_mem_wdata, f_mem_rdata;

  int checks = 0;
  int passed = 0;

  lc3b_mem_arbiter #(.FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  lc3b_mem_arbiter #(.FIXED_PRIO(1'b1)) dut_fixed (
    .clk(clk), .rst(rst),
    .i_read(f_i_read), .i_address(f_i_address), .i_rdata(f_i_rdata), .i_resp(f_i_resp),
    .d_read(f_d_read), .d_write(f_d_write), .d_address(f_d_address), .d_wdata(f_d_wdata),
    .d_wmask(f_d_wmask), .d_rdata(f_d_rdata), .d_resp(f_d_resp),
    .mem_read(f_mem_read), .mem_write(f_mem_write), .mem_address(f_mem_address),
    .mem_wdata(f_mem_wdata), .mem_wmask(f_mem_wmask), .mem_rdata(f_mem_rdata), .mem_resp(f_mem_resp)
  );

  // Bounded wait for a strobe on the round-robin instance; returns at negedge+1.
  task automatic wait_strobe(output bit found);
    found = 1'b0;
    for (int n = 0; n < 8 && !found; n++) begin
      @(negedge clk); #1;
      if (mem_read || mem_write) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (mem_read !== 1'b0) $display("FAIL rst_mem_read: got %b want 0", mem_read); else passed++;
    checks++; if (mem_write !== 1'b0) $display("FAIL rst_mem_write: got %b want 0", mem_write); else passed++;
    checks++; if (mem_address !== 16'h0000) $display("FAIL rst_mem_address: got %h want 0000", mem_address); else passed++;
    checks++; if (mem_wdata !== 16'h0000) $display("FAIL rst_mem_wdata: got %h want 0000", mem_wdata); else passed++;
    checks++; if (mem_wmask !== 2'b00) $display("FAIL rst_mem_wmask: got %b want 00", mem_wmask); else passed++;
    checks++; if (f_mem_read !== 1'b0) $display("FAIL rst_f_mem_read: got %b want 0", f_mem_read); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    bit found;
    i_read = 1'b1; i_address = 16'h0040;
    wait_strobe(found);
    checks++; if (found !== 1'b1) $display("FAIL rd_timeout: got no strobe want strobe"); else passed++;
    checks++; if (mem_read !== 1'b1) $display("FAIL rd_mem_read: got %b want 1", mem_read); else passed++;
    checks++; if (mem_address !== 16'h0040) $display("FAIL rd_mem_address: got %h want 0040", mem_address); else passed++;
    checks++; if (mem_wmask !== 2'b00) $display("FAIL rd_mem_wmask: got %b want 00", mem_wmask); else passed++;
    @(negedge clk); #1;
    checks++; if (mem_read !== 1'b1 || i_resp !== 1'b0) $display("FAIL rd_hold: got read=%b resp=%b want 1/0", mem_read, i_resp); else passed++;
    @(negedge clk); #1;
    mem_rdata = 16'h1234; mem_resp = 1'b1; #1;
    checks++; if (i_resp !== 1'b1) $display("FAIL rd_i_resp: got %b want 1", i_resp); else passed++;
    checks++; if (i_rdata !== 16'h1234) $display("FAIL rd_i_rdata: got %h want 1234", i_rdata); else passed++;
    checks++; if (d_resp !== 1'b0) $display("FAIL rd_d_resp: got %b want 0", d_resp); else passed++;
    i_read = 1'b0;
    @(negedge clk); #1;
    mem_resp = 1'b0; #1;
    checks++; if (mem_read !== 1'b0 || i_resp !== 1'b0) $display("FAIL rd_after: got read=%b resp=%b want 0/0", mem_read, i_resp); else passed++;
  endtask

  task automatic test_round_robin();
    bit found;
    logic [15:0] exp_addr;
    rst = 1'b1;
    i_read = 1'b1; i_address = 16'h0100;
    d_read = 1'b1; d_address = 16'h0200;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_addr = (k % 2 == 0) ? 16'h0100 : 16'h0200;
      wait_strobe(found);
      checks++; if (found !== 1'b1) $display("FAIL rr_timeout_%0d: got no strobe want strobe", k); else passed++;
      checks++; if (mem_address !== exp_addr) $display("FAIL rr_addr_%0d: got %h want %h", k, mem_address, exp_addr); else passed++;
      mem_rdata = 16'hA000 + 16'(k); mem_resp = 1'b1; #1;
      checks++; if (i_resp !== (k % 2 == 0) || d_resp !== (k % 2 == 1))
        $display("FAIL rr_resp_%0d: got i=%b d=%b want i=%b d=%b", k, i_resp, d_resp, (k % 2 == 0), (k % 2 == 1));
      else passed++;
      @(negedge clk); #1;
      mem_resp = 1'b0;
    end
    i_read = 1'b0; d_read = 1'b0;
  endtask

  task automatic test_write();
    bit found;
    d_write = 1'b1; d_address = 16'h0101; d_wdata = 16'hBEEF; d_wmask = 2'b10;
    wait_strobe(found);
    checks++; if (found !== 1'b1) $display("FAIL wr_timeout: got no strobe want strobe"); else passed++;
    checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0) $display("FAIL wr_strobes: got w=%b r=%b want 1/0", mem_write, mem_read); else passed++;
    checks++; if (mem_wmask !== 2'b10) $display("FAIL wr_wmask: got %b want 10", mem_wmask); else passed++;
    checks++; if (mem_wdata !== 16'hBEEF) $display("FAIL wr_wdata: got %h want beef", mem_wdata); else passed++;
    checks++; if (mem_address !== 16'h0101) $display("FAIL wr_addr: got %h want 0101", mem_address); else passed++;
    d_address = 16'h0555; d_wdata = 16'h0000;
    @(negedge clk); #1;
    checks++; if (mem_address !== 16'h0101 || mem_wdata !== 16'hBEEF || mem_write !== 1'b1)
      $display("FAIL wr_hold: got a=%h d=%h w=%b want 0101/beef/1", mem_address, mem_wdata, mem_write);
    else passed++;
    checks++; if (d_resp !== 1'b0) $display("FAIL wr_early_resp: got %b want 0", d_resp); else passed++;
    mem_resp = 1'b1; #1;
    checks++; if (d_resp !== 1'b1 || i_resp !== 1'b0) $display("FAIL wr_resp: got d=%b i=%b want 1/0", d_resp, i_resp); else passed++;
    @(negedge clk); #1;
    mem_resp = 1'b0; d_write = 1'b0; #1;
    checks++; if (d_resp !== 1'b0 || mem_write !== 1'b0) $display("FAIL wr_after: got resp=%b w=%b want 0/0", d_resp, mem_write); else passed++;
  endtask

  task automatic test_rw_and_stray();
    bit found;
    d_read = 1'b1; d_write = 1'b1; d_address = 16'h0300; d_wdata = 16'h5A5A; d_wmask = 2'b01;
    wait_strobe(found);
    checks++; if (found !== 1'b1) $display("FAIL rw_timeout: got no strobe want strobe"); else passed++;
    checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0) $display("FAIL rw_strobes: got w=%b r=%b want 1/0", mem_write, mem_read); else passed++;
    checks++; if (mem_wmask !== 2'b01) $display("FAIL rw_wmask: got %b want 01", mem_wmask); else passed++;
    mem_resp = 1'b1; #1;
    checks++; if (d_resp !== 1'b1) $display("FAIL rw_resp: got %b want 1", d_resp); else passed++;
    @(negedge clk); #1;
    mem_resp = 1'b0; d_read = 1'b0; d_write = 1'b0;
    @(negedge clk); #1;
    mem_resp = 1'b1; #1;
    checks++; if (i_resp !== 1'b0 || d_resp !== 1'b0) $display("FAIL stray_resp: got i=%b d=%b want 0/0", i_resp, d_resp); else passed++;
    @(negedge clk); #1;
    mem_resp = 1'b0; #1;
    checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) $display("FAIL stray_strobes: got r=%b w=%b want 0/0", mem_read, mem_write); else passed++;
  endtask

  task automatic test_reset_mid();
    bit found;
    d_read = 1'b1; d_address = 16'h0400;
    wait_strobe(found);
    checks++; if (found !== 1'b1 || mem_address !== 16'h0400) $display("FAIL rm_grant: got found=%b a=%h want 1/0400", found, mem_address); else passed++;
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0; mem_resp = 1'b1; i_read = 1'b1; i_address = 16'h0140; #1;
    checks++; if (d_resp !== 1'b0 || i_resp !== 1'b0) $display("FAIL rm_resp: got d=%b i=%b want 0/0", d_resp, i_resp); else passed++;
    checks++; if (mem_read !== 1'b0 || mem_address !== 16'h0000) $display("FAIL rm_cleared: got r=%b a=%h want 0/0000", mem_read, mem_address); else passed++;
    @(negedge clk); #1;
    mem_resp = 1'b0; #1;
    checks++; if (mem_read !== 1'b1 || mem_address !== 16'h0140) $display("FAIL rm_tie_i: got r=%b a=%h want 1/0140", mem_read, mem_address); else passed++;
    mem_resp = 1'b1; #1;
    checks++; if (i_resp !== 1'b1 || d_resp !== 1'b0) $display("FAIL rm_i_done: got i=%b d=%b want 1/0", i_resp, d_resp); else passed++;
    @(negedge clk); #1;
    mem_resp = 1'b0; i_read = 1'b0; d_read = 1'b0;
  endtask

  task automatic test_fixed_prio();
    bit found;
    f_i_read = 1'b1; f_i_address = 16'h0100;
    f_d_read = 1'b1; f_d_address = 16'h0200;
    f_mem_rdata = 16'h0F0F;
    for (int k = 0; k < 3; k++) begin
      found = 1'b0;
      for (int n = 0; n < 8 && !found; n++) begin
        @(negedge clk); #1;
        if (f_mem_read || f_mem_write) found = 1'b1;
      end
      checks++; if (found !== 1'b1 || f_mem_address !== 16'h0200)
        $display("FAIL fp_grant_d_%0d: got found=%b a=%h want 1/0200", k, found, f_mem_address);
      else passed++;
      f_mem_resp = 1'b1; #1;
      checks++; if (f_d_resp !== 1'b1 || f_i_resp !== 1'b0 || f_d_rdata !== 16'h0F0F)
        $display("FAIL fp_resp_%0d: got d=%b i=%b rd=%h want 1/0/0f0f", k, f_d_resp, f_i_resp, f_d_rdata);
      else passed++;
      @(negedge clk); #1;
      f_mem_resp = 1'b0;
    end
    f_d_read = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 8 && !found; n++) begin
      @(negedge clk); #1;
      if (f_mem_read || f_mem_write) found = 1'b1;
    end
    checks++; if (found !== 1'b1 || f_mem_address !== 16'h0100)
      $display("FAIL fp_grant_i: got found=%b a=%h want 1/0100", found, f_mem_address);
    else passed++;
    f_mem_resp = 1'b1; #1;
    checks++; if (f_i_resp !== 1'b1) $display("FAIL fp_i_resp: got %b want 1", f_i_resp); else passed++;
    @(negedge clk); #1;
    f_mem_resp = 1'b0; f_i_read = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    i_read = 1'b0; i_address = 16'h0000;
    d_read = 1'b0; d_write = 1'b0; d_address = 16'h0000; d_wdata = 16'h0000; d_wmask = 2'b00;
    mem_rdata = 16'h0000; mem_resp = 1'b0;
    f_i_read = 1'b0; f_i_address = 16'h0000;
    f_d_read = 1'b0; f_d_write = 1'b0; f_d_address = 16'h0000; f_d_wdata = 16'h0000; f_d_wmask = 2'b00;
    f_mem_rdata = 16'h0000; f_mem_resp = 1'b0;

    test_reset();
    test_single_read();
    test_round_robin();
    test_write();
    test_rw_and_stray();
    test_reset_mid();
    test_fixed_prio();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
